// File: rtl/kernel_pkg.sv
// Shared constants for the kernel bank: default widths, preset 5x5 kernels and load FSM states.
package kernel_pkg;

  localparam int unsigned KSIZE_DEF = 5;
  localparam int unsigned KW_DEF    = 4;
  localparam int unsigned DIVW_DEF  = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StCommit = 2'd2
  } load_state_e;

  // 5x5 presets at 4-bit coefficients, tap 0 (top-left) in the MSBs, one row per group.
  localparam logic [99:0] KERN_PASS    = 100'h00000_00000_00100_00000_00000;
  localparam logic [99:0] KERN_SOBEL   = 100'h00000_0F010_0E020_0F010_00000;
  localparam logic [99:0] KERN_BLUR    = 100'h01110_12221_12421_12221_01110;
  localparam logic [99:0] KERN_SHARPEN = 100'h00000_00F00_0F5F0_00F00_00000;

  localparam int unsigned DIV_PASS    = 0;
  localparam int unsigned DIV_SOBEL   = 0;
  localparam int unsigned DIV_BLUR    = 5;
  localparam int unsigned DIV_SHARPEN = 0;

  function automatic int preset_coef(input int unsigned id, input int unsigned tap);
    logic [99:0] k;
    logic [3:0]  n;
    case (id)
      0:       k = KERN_PASS;
      1:       k = KERN_SOBEL;
      2:       k = KERN_BLUR;
      default: k = KERN_SHARPEN;
    endcase
    n = k[(24 - tap) * 4 +: 4];
    return int'($signed(n));
  endfunction

  function automatic int unsigned preset_div(input int unsigned id);
    case (id)
      0:       return DIV_PASS;
      1:       return DIV_SOBEL;
      2:       return DIV_BLUR;
      default: return DIV_SHARPEN;
    endcase
  endfunction

endpackage

// File: rtl/kernel_load_ctrl.sv
// Slot-load sequencer: accepts a load request, collects TAPS coefficient beats into a staging
// register and presents them for a single-cycle commit.
module kernel_load_ctrl
  import kernel_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned KSIZE     = KSIZE_DEF,
  parameter int unsigned KW        = KW_DEF,
  parameter int unsigned DIVW      = DIVW_DEF,
  parameter int unsigned SW        = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ld_start,
  input  logic [SW-1:0]               ld_slot,
  input  logic [DIVW-1:0]             ld_div,
  input  logic                        wr_valid,
  input  logic [KW-1:0]               wr_coef,
  output logic                        wr_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        cm_en,
  output logic [SW-1:0]               cm_slot,
  output logic [DIVW-1:0]             cm_div,
  output logic [KSIZE*KSIZE*KW-1:0]   cm_kernel
);

  localparam int unsigned TAPS = KSIZE * KSIZE;
  localparam int unsigned CW   = $clog2(TAPS);
  localparam logic [SW-1:0] SLOT_LIM = SW'(NUM_SLOTS);

  load_state_e             r_state, w_state_d;
  logic [CW-1:0]           r_cnt;
  logic [SW-1:0]           r_slot;
  logic [DIVW-1:0]         r_div;
  logic [TAPS*KW-1:0]      r_stage;
  logic                    r_err;
  logic                    w_beat;
  logic                    w_accept;

  assign w_beat   = wr_valid && (r_state == StLoad);
  assign w_accept = (r_state == StIdle) && ld_start && (ld_slot < SLOT_LIM);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_d = StLoad;
      StLoad:   if (w_beat && (r_cnt == CW'(TAPS - 1))) w_state_d = StCommit;
      StCommit: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_div   <= '0;
      r_stage <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= (r_state == StIdle) && ld_start && !(ld_slot < SLOT_LIM);
      if (w_accept) begin
        r_cnt  <= '0;
        r_slot <= ld_slot;
        r_div  <= ld_div;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
        for (int unsigned t = 0; t < TAPS; t++) begin
          if (r_cnt == CW'(t)) r_stage[(TAPS-1-t)*KW +: KW] <= wr_coef;
        end
      end
    end
  end

  assign wr_ready  = (r_state == StLoad);
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StCommit);
  assign err       = r_err;
  assign cm_en     = (r_state == StCommit);
  assign cm_slot   = r_slot;
  assign cm_div    = r_div;
  assign cm_kernel = r_stage;

endmodule

// File: rtl/kernel_bank.sv
// Bank of NUM_SLOTS convolution kernels with frame-synchronous active-kernel selection.
// Define KERNEL_READBACK_EN to add the registered rd_slot/rd_tap -> rd_coef readback port.
module kernel_bank
  import kernel_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned KSIZE     = KSIZE_DEF,
  parameter int unsigned KW        = KW_DEF,
  parameter int unsigned DIVW      = DIVW_DEF
) (
  input  logic                              clk,
`ifdef KERNEL_READBACK_EN
  input  logic [$clog2(NUM_SLOTS+1)-1:0]    rd_slot,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]    rd_tap,
  output logic [KW-1:0]                     rd_coef,
`endif
  input  logic                              rst_n,
  input  logic                              frame_start,
  // Slot indices carry one spare bit so out-of-range requests are expressible and rejected.
  input  logic [$clog2(NUM_SLOTS+1)-1:0]    sel,
  input  logic                              ld_start,
  input  logic [$clog2(NUM_SLOTS+1)-1:0]    ld_slot,
  input  logic [DIVW-1:0]                   ld_div,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [KW-1:0]                     wr_coef,
  output logic [KSIZE*KSIZE*KW-1:0]         kernel,
  output logic [DIVW-1:0]                   div,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int unsigned TAPS   = KSIZE * KSIZE;
  localparam int unsigned KB     = TAPS * KW;
  localparam int unsigned SW     = $clog2(NUM_SLOTS + 1);
  localparam int unsigned CENTRE = TAPS / 2;

  logic [KB-1:0]   r_slot [NUM_SLOTS];
  logic [DIVW-1:0] r_sdiv [NUM_SLOTS];
  logic [KB-1:0]   r_kernel;
  logic [DIVW-1:0] r_div;

  logic            w_cm_en;
  logic [SW-1:0]   w_cm_slot;
  logic [DIVW-1:0] w_cm_div;
  logic [KB-1:0]   w_cm_kernel;

  function automatic logic [KB-1:0] rst_kernel(input int unsigned s);
    logic [KB-1:0] k;
    k = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      if (KSIZE == 5) k[(TAPS-1-t)*KW +: KW] = KW'(preset_coef((s < 4) ? s : 0, t));
      else if (t == CENTRE) k[(TAPS-1-t)*KW +: KW] = KW'(1);
    end
    return k;
  endfunction

  function automatic logic [DIVW-1:0] rst_div(input int unsigned s);
    return (KSIZE == 5) ? DIVW'(preset_div((s < 4) ? s : 0)) : '0;
  endfunction

  kernel_load_ctrl #(
    .NUM_SLOTS (NUM_SLOTS),
    .KSIZE     (KSIZE),
    .KW        (KW),
    .DIVW      (DIVW),
    .SW        (SW)
  ) u_load_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_slot   (ld_slot),
    .ld_div    (ld_div),
    .wr_valid  (wr_valid),
    .wr_coef   (wr_coef),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cm_en     (w_cm_en),
    .cm_slot   (w_cm_slot),
    .cm_div    (w_cm_div),
    .cm_kernel (w_cm_kernel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        r_slot[s] <= rst_kernel(s);
        r_sdiv[s] <= rst_div(s);
      end
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (w_cm_en && (w_cm_slot == SW'(s))) begin
          r_slot[s] <= w_cm_kernel;
          r_sdiv[s] <= w_cm_div;
        end
      end
    end
  end

  // Slot contents are read before the same-edge commit, so a coincident frame keeps the old kernel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kernel <= rst_kernel(0);
      r_div    <= '0;
    end else if (frame_start) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (sel == SW'(s)) begin
          r_kernel <= r_slot[s];
          r_div    <= r_sdiv[s];
        end
      end
    end
  end

  assign kernel = r_kernel;
  assign div    = r_div;

`ifdef KERNEL_READBACK_EN
  logic [KW-1:0] r_rd_coef;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_coef <= '0;
    end else begin
      r_rd_coef <= '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        for (int unsigned t = 0; t < TAPS; t++) begin
          if ((rd_slot == SW'(s)) && (rd_tap == $clog2(TAPS)'(t))) begin
            r_rd_coef <= r_slot[s][(TAPS-1-t)*KW +: KW];
          end
        end
      end
    end
  end

  assign rd_coef = r_rd_coef;
`endif

endmodule

// File: tb/tb_kernel_bank.sv
// Directed bench for kernel_bank at default parameters; expected kernels are written out by hand.
module tb_kernel_bank;

  localparam int unsigned TAPS = 25;
  localparam int unsigned KB   = 100;

  localparam logic [KB-1:0] EXP_PASS    = 100'h00000_00000_00100_00000_00000;
  localparam logic [KB-1:0] EXP_SOBEL   = 100'h00000_0F010_0E020_0F010_00000;
  localparam logic [KB-1:0] EXP_BLUR    = 100'h01110_12221_12421_12221_01110;
  localparam logic [KB-1:0] EXP_SHARPEN = 100'h00000_00F00_0F5F0_00F00_00000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic [2:0]    sel;
  logic          ld_start;
  logic [2:0]    ld_slot;
  logic [3:0]    ld_div;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_coef;
  logic [KB-1:0] kernel;
  logic [3:0]    div;
  logic          busy;
  logic          done;
  logic          err;
`ifdef KERNEL_READBACK_EN
  logic [2:0]    rd_slot;
  logic [4:0]    rd_tap;
  logic [3:0]    rd_coef;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  kernel_bank dut (
    .clk         (clk),
`ifdef KERNEL_READBACK_EN
    .rd_slot     (rd_slot),
    .rd_tap      (rd_tap),
    .rd_coef     (rd_coef),
`endif
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .sel         (sel),
    .ld_start    (ld_start),
    .ld_slot     (ld_slot),
    .ld_div      (ld_div),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_coef     (wr_coef),
    .kernel      (kernel),
    .div         (div),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string tag, input logic [KB-1:0] got, input logic [KB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] coef(input int p, input int i);
    return (p == 0) ? 4'((i % 9) + 1) : 4'(15 - i);
  endfunction

  function automatic logic [KB-1:0] pattern(input int p);
    logic [KB-1:0] v;
    v = '0;
    for (int i = 0; i < TAPS; i++) v[(TAPS-1-i)*4 +: 4] = coef(p, i);
    return v;
  endfunction

  task automatic frame(input logic [2:0] s);
    @(negedge clk);
    frame_start = 1'b1;
    sel         = s;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Loads nb beats with a wr_valid gap before every fourth beat; a stray ld_start rides beat 5.
  task automatic load(input logic [2:0] slot, input logic [3:0] d, input int p, input int nb,
                      input bit fs_commit);
    @(negedge clk);
    ld_start = 1'b1;
    ld_slot  = slot;
    ld_div   = d;
    @(negedge clk);
    ld_start = 1'b0;
    check("busy_in_load", KB'(busy), KB'(1));
    check("wr_ready_in_load", KB'(wr_ready), KB'(1));
    for (int i = 0; i < nb; i++) begin
      if (i % 4 == 3) begin
        wr_valid = 1'b0;
        @(negedge clk);
      end
      wr_valid = 1'b1;
      wr_coef  = coef(p, i);
      if (i == 5) begin
        ld_start = 1'b1;
        ld_slot  = 3'd3;
      end
      @(negedge clk);
      ld_start = 1'b0;
    end
    wr_valid = 1'b0;
    if (nb == TAPS) begin
      check("done_at_commit", KB'(done), KB'(1));
      check("busy_at_commit", KB'(busy), KB'(1));
      check("no_err_busy_ld", KB'(err), KB'(0));
      if (fs_commit) begin
        frame_start = 1'b1;
        sel         = slot;
      end
      @(negedge clk);
      frame_start = 1'b0;
      check("done_pulse_end", KB'(done), KB'(0));
      check("idle_after_commit", KB'(busy), KB'(0));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    sel         = '0;
    ld_start    = 1'b0;
    ld_slot     = '0;
    ld_div      = '0;
    wr_valid    = 1'b0;
    wr_coef     = '0;
`ifdef KERNEL_READBACK_EN
    rd_slot     = '0;
    rd_tap      = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_kernel", kernel, EXP_PASS);
    check("rst_div", KB'(div), KB'(0));
    check("rst_busy", KB'(busy), KB'(0));
    check("rst_wr_ready", KB'(wr_ready), KB'(0));
    check("rst_done", KB'(done), KB'(0));
    check("rst_err", KB'(err), KB'(0));

    frame(3'd2);
    check("blur_kernel", kernel, EXP_BLUR);
    check("blur_div", KB'(div), KB'(5));

    sel = 3'd1;
    repeat (2) @(negedge clk);
    check("sel_no_frame", kernel, EXP_BLUR);

    load(3'd1, 4'd3, 0, TAPS, 1'b0);
    frame(3'd1);
    check("slot1_kernel", kernel, pattern(0));
    check("slot1_div", KB'(div), KB'(3));

`ifdef KERNEL_READBACK_EN
    @(negedge clk);
    rd_slot = 3'd1;
    rd_tap  = 5'd12;
    @(negedge clk);
    check("readback_tap12", KB'(rd_coef), KB'(4));
`endif

    @(negedge clk);
    ld_start = 1'b1;
    ld_slot  = 3'd7;
    ld_div   = 4'd9;
    @(negedge clk);
    ld_start = 1'b0;
    check("reject_err", KB'(err), KB'(1));
    check("reject_busy", KB'(busy), KB'(0));
    @(negedge clk);
    check("reject_err_pulse", KB'(err), KB'(0));
    check("reject_still_idle", KB'(wr_ready), KB'(0));

    frame(3'd0);
    check("slot0_kept", kernel, EXP_PASS);
    frame(3'd1);
    check("slot1_kept", kernel, pattern(0));
    frame(3'd2);
    check("slot2_kept", kernel, EXP_BLUR);
    frame(3'd3);
    check("slot3_kept", kernel, EXP_SHARPEN);
    frame(3'd5);
    check("sel_oob_hold", kernel, EXP_SHARPEN);
    check("sel_oob_hold_div", KB'(div), KB'(0));

    frame(3'd2);
    load(3'd2, 4'd2, 1, TAPS, 1'b1);
    check("coinc_old_kernel", kernel, EXP_BLUR);
    check("coinc_old_div", KB'(div), KB'(5));
    frame(3'd2);
    check("coinc_new_kernel", kernel, pattern(1));
    check("coinc_new_div", KB'(div), KB'(2));

    load(3'd3, 4'd1, 0, 10, 1'b0);
    check("abort_busy_pre", KB'(busy), KB'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", KB'(busy), KB'(0));
    check("abort_wr_ready", KB'(wr_ready), KB'(0));
    check("abort_kernel", kernel, EXP_PASS);
    check("abort_div", KB'(div), KB'(0));
    wr_valid = 1'b1;
    wr_coef  = 4'h7;
    @(negedge clk);
    wr_valid = 1'b0;
    check("idle_no_ready", KB'(wr_ready), KB'(0));
    frame(3'd3);
    check("abort_slot3", kernel, EXP_SHARPEN);
    frame(3'd1);
    check("reset_slot1", kernel, EXP_SOBEL);
    frame(3'd2);
    check("reset_slot2", kernel, EXP_BLUR);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
